// File: rtl/audio_pkg.sv
// Shared audio types and constants for the codec-facing serial blocks.
package audio_pkg;

  localparam int unsigned W_DEFAULT = 16;

  typedef logic signed [W_DEFAULT-1:0] sample_t;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    SHIFT     = 1'b1
  } tx_state_t;

  localparam logic [15:0] UNDERRUN_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO with a registered occupancy count; read data is the head entry.
module sample_fifo #(
  parameter int unsigned W          = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  pop_data_c,
  output logic                          full_c,
  output logic                          empty_c,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c     = (level == LW'(FIFO_DEPTH));
  assign empty_c    = (level == '0);
  assign do_push    = push && !full_c;
  assign do_pop     = pop && !empty_c;
  assign pop_data_c = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: FIFO-buffered samples serialised MSB-first against
// codec-mastered BCLK/LRCK, which are sampled on clk rather than used as clocks.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned W           = W_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MONO        = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         aud_bclk,
  input  logic                         aud_daclrck,
  output logic                         aud_dacdat,
  input  logic [W-1:0]                 sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         mute,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         underrun,
  output logic [15:0]                  underrun_count
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_d;
  logic                   lrck_prev;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   bclk_fall;
  logic                   left_bnd;
  logic                   right_bnd;

  tx_state_t              state;
  logic [W-1:0]           hold;
  logic [W-1:0]           shreg;
  logic [CW-1:0]          bitcnt;

  logic                   fifo_full_c;
  logic                   fifo_empty_c;
  logic [W-1:0]           fifo_dout_c;
  logic                   pop_req_c;
  logic                   load_c;
  logic                   underrun_c;
  logic [W-1:0]           pop_val_c;
  logic [W-1:0]           slot_c;

  sample_fifo #(
    .W          (W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (sample_valid),
    .push_data  (sample_data),
    .pop        (pop_req_c),
    .pop_data_c (fifo_dout_c),
    .full_c     (fifo_full_c),
    .empty_c    (fifo_empty_c),
    .level      (fifo_level)
  );

  assign sample_ready = !fifo_full_c;

  // Synchronise both codec clocks through identical depths so their relative timing holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_d    <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= (bclk_sync << 1) | SYNC_STAGES'(aud_bclk);
      lrck_sync <= (lrck_sync << 1) | SYNC_STAGES'(aud_daclrck);
      bclk_d    <= bclk_s;
      if (bclk_fall) lrck_prev <= lrck_s;
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign bclk_fall = bclk_d && !bclk_s;
  assign left_bnd  = bclk_fall && lrck_prev && !lrck_s;
  assign right_bnd = bclk_fall && !lrck_prev && lrck_s;

  // Right slot only pops in stereo; in mono it replays the held left sample.
  assign pop_req_c  = left_bnd || (right_bnd && (state == SHIFT) && (MONO == 0));
  assign load_c     = left_bnd || (right_bnd && (state == SHIFT));
  assign underrun_c = pop_req_c && fifo_empty_c;
  assign pop_val_c  = fifo_empty_c ? '0 : fifo_dout_c;
  assign slot_c     = mute ? '0 : (pop_req_c ? pop_val_c : hold);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= WAIT_SYNC;
      hold           <= '0;
      shreg          <= '0;
      bitcnt         <= '0;
      aud_dacdat     <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= underrun_c;
      if (underrun_c && (underrun_count != UNDERRUN_CNT_MAX))
        underrun_count <= underrun_count + 16'd1;
      if (pop_req_c) hold <= pop_val_c;
      if (load_c) begin
        state      <= SHIFT;
        shreg      <= slot_c;
        aud_dacdat <= slot_c[W-1];
        bitcnt     <= CW'(1);
      end else if (bclk_fall) begin
        if ((state == SHIFT) && (bitcnt < CW'(W))) begin
          shreg      <= shreg << 1;
          aud_dacdat <= shreg[W-2];
          bitcnt     <= bitcnt + CW'(1);
        end else begin
          aud_dacdat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a mono and a stereo instance share one emulated codec
// and are checked every bit period against a slot-level behavioural model.
module tb_i2s_dac_tx;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             aud_bclk;
  logic             aud_daclrck;
  logic [15:0]      sample_data;
  logic             sample_valid;
  logic             mute;
  logic [1:0]       dacdat;
  logic [1:0]       ready;
  logic [1:0]       urun;
  logic [1:0][2:0]  level;
  logic [1:0][15:0] ucnt;

  always #10 clk = ~clk;

  i2s_dac_tx #(.W(W), .FIFO_DEPTH(DEPTH), .MONO(1), .SYNC_STAGES(2)) dut_mono (
    .clk(clk), .reset(reset), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(dacdat[0]), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(ready[0]), .mute(mute), .fifo_level(level[0]),
    .underrun(urun[0]), .underrun_count(ucnt[0])
  );

  i2s_dac_tx #(.W(W), .FIFO_DEPTH(DEPTH), .MONO(0), .SYNC_STAGES(2)) dut_stereo (
    .clk(clk), .reset(reset), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(dacdat[1]), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(ready[1]), .mute(mute), .fifo_level(level[1]),
    .underrun(urun[1]), .underrun_count(ucnt[1])
  );

  int          total = 0;
  int          bad   = 0;
  int          pos;
  logic [15:0] mq [2][DEPTH];
  int          mcnt [2];
  logic [15:0] mhold [2];
  logic [15:0] mslot [2];
  int          mk [2];
  bit          msync [2];
  int          muc [2];
  int          mpulse [2];
  logic        exp_dat [2];
  logic        mprev;
  logic [63:0] cap [2];
  int          npulse [2] = '{0, 0};
  bit          wide [2]   = '{1'b0, 1'b0};
  logic [1:0]  uprev      = 2'b00;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Underrun pulse observer: counts pulses and flags any pulse longer than one clk.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        npulse[d] = 0;
        wide[d]   = 1'b0;
      end else begin
        if (urun[d] && uprev[d]) wide[d] = 1'b1;
        if (urun[d] && !uprev[d]) npulse[d]++;
      end
    end
    uprev = urun;
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; mhold[d] = '0; mslot[d] = '0; mk[d] = 0; msync[d] = 1'b0;
      muc[d] = 0; mpulse[d] = 0; exp_dat[d] = 1'b0;
    end
    mprev = 1'b0;
  endtask

  // Slot-level model: at each BCLK fall work out which bit of which slot value is due.
  task automatic model_fall();
    logic seen, lb, rb;
    if (!reset) return;
    seen  = aud_daclrck;
    lb    = mprev && !seen;
    rb    = !mprev && seen;
    mprev = seen;
    for (int d = 0; d < 2; d++) begin
      if (lb || (rb && msync[d])) begin
        if (lb || d == 1) begin
          if (mcnt[d] == 0) begin
            mhold[d] = '0;
            mpulse[d]++;
            if (muc[d] < 65535) muc[d]++;
          end else begin
            mhold[d] = mq[d][0];
            for (int j = 0; j < int'(DEPTH) - 1; j++) mq[d][j] = mq[d][j+1];
            mcnt[d]--;
          end
        end
        mslot[d] = mute ? 16'h0 : mhold[d];
        mk[d]    = 1;
        msync[d] = 1'b1;
      end else if (msync[d] && mk[d] <= int'(W)) begin
        mk[d]++;
      end
      exp_dat[d] = (mk[d] >= 1 && mk[d] <= int'(W)) ? mslot[d][int'(W) - mk[d]] : 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk("dacdat", d, 64'(dacdat[d]), 64'(exp_dat[d]));
      chk("fifo_level", d, 64'(level[d]), 64'(mcnt[d]));
      chk("underrun_count", d, 64'(ucnt[d]), 64'(muc[d]));
      chk("underrun_pulses", d, 64'(npulse[d]), 64'(mpulse[d]));
      chk("underrun_width", d, 64'(wide[d]), 64'd0);
      cap[d] = {cap[d][62:0], dacdat[d]};
    end
  endtask

  // One BCLK period: fall, LRCK moves shortly after the fall, sample data mid-period.
  task automatic run_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      aud_bclk = 1'b0;
      pos++;
      model_fall();
      repeat (2) @(negedge clk);
      if (pos % 64 == 0) aud_daclrck = 1'b0;
      else if (pos % 64 == 32) aud_daclrck = 1'b1;
      repeat (6) @(negedge clk);
      aud_bclk = 1'b1;
      compare_all();
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic run_frame();
    cap[0] = '0;
    cap[1] = '0;
    run_bits(64);
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk);
    sample_data  = v;
    sample_valid = 1'b1;
    for (int d = 0; d < 2; d++) chk("sample_ready", d, 64'(ready[d]), 64'(mcnt[d] < int'(DEPTH)));
    @(negedge clk);
    sample_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (mcnt[d] < int'(DEPTH)) begin
        mq[d][mcnt[d]] = v;
        mcnt[d]++;
      end
      chk("fifo_level_push", d, 64'(level[d]), 64'(mcnt[d]));
    end
  endtask

  initial begin
    reset = 1'b0; aud_bclk = 1'b1; aud_daclrck = 1'b1;
    sample_data = '0; sample_valid = 1'b0; mute = 1'b0;
    pos = 32;
    model_reset();
    cap[0] = '0; cap[1] = '0;
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_dacdat", d, 64'(dacdat[d]), 64'd0);
      chk("reset_ready", d, 64'(ready[d]), 64'd1);
      chk("reset_level", d, 64'(level[d]), 64'd0);
      chk("reset_underrun", d, 64'(urun[d]), 64'd0);
      chk("reset_count", d, 64'(ucnt[d]), 64'd0);
    end
    @(negedge clk) reset = 1'b1;
    repeat (4) @(negedge clk);
    run_bits(32);

    // Basic frame
    push(16'hA5C3);
    run_frame();
    chk("lit_basic_frame", 0, cap[0], 64'hA5C3_0000_A5C3_0000);
    chk("lit_basic_frame", 1, cap[1], 64'hA5C3_0000_0000_0000);
    chk("lit_basic_count", 0, 64'(ucnt[0]), 64'd0);
    chk("lit_basic_count", 1, 64'(ucnt[1]), 64'd1);

    // Underrun
    run_frame();
    chk("lit_underrun_frame", 0, cap[0], 64'd0);
    chk("lit_underrun_count", 0, 64'(ucnt[0]), 64'd1);
    chk("lit_underrun_count", 1, 64'(ucnt[1]), 64'd3);

    // Full FIFO
    for (int i = 1; i <= 5; i++) push(16'(i));
    chk("lit_full_level", 0, 64'(level[0]), 64'd4);
    chk("lit_full_ready", 0, 64'(ready[0]), 64'd0);
    chk("lit_full_ready", 1, 64'(ready[1]), 64'd0);
    for (int f = 0; f < 5; f++) begin
      logic [15:0] v;
      run_frame();
      v = (f < 4) ? 16'(f + 1) : 16'h0;
      chk("lit_full_frame", 0, cap[0], {v, 16'h0, v, 16'h0});
    end
    chk("lit_full_count", 0, 64'(ucnt[0]), 64'd2);
    chk("lit_full_count", 1, 64'(ucnt[1]), 64'd9);

    // Mute
    mute = 1'b1;
    push(16'h7FFF);
    run_frame();
    mute = 1'b0;
    chk("lit_mute_frame", 0, cap[0], 64'd0);
    chk("lit_mute_level", 0, 64'(level[0]), 64'd0);
    chk("lit_mute_count", 0, 64'(ucnt[0]), 64'd2);

    // Negative sample, stereo ordering
    push(16'h8000);
    push(16'h0001);
    run_frame();
    chk("lit_neg_frame", 1, cap[1], 64'h8000_0000_0001_0000);
    chk("lit_neg_frame", 0, cap[0], 64'h8000_0000_8000_0000);
    run_frame();

    // Reset mid-frame at bit 7 of a left slot
    push(16'h0300);
    push(16'h1111);
    run_bits(7);
    chk("lit_bit7", 0, 64'(dacdat[0]), 64'd1);
    chk("lit_bit7", 1, 64'(dacdat[1]), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) chk("async_reset_dacdat", d, 64'(dacdat[d]), 64'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_flush_level", d, 64'(level[d]), 64'd0);
      chk("reset_flush_count", d, 64'(ucnt[d]), 64'd0);
    end
    run_bits(24);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    cap[0] = '0; cap[1] = '0;
    run_bits(33);
    chk("lit_resync_quiet", 0, cap[0], 64'd0);
    push(16'hC001);
    run_frame();
    chk("lit_resync_frame", 0, cap[0], 64'hC001_0000_C001_0000);
    chk("lit_resync_frame", 1, cap[1], 64'hC001_0000_0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
